// File: rtl/axi4_master.sv
// Single-outstanding AXI4-Lite master: turns one user command into one AXI4-Lite
// read or write and returns its data/response on a ready/valid completion port.
module axi4_master #(
   parameter logic [2:0] PROT = 3'b000
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        awvalid,
   input  logic        awready,
   output logic [15:0] awaddr,
   output logic [2:0]  awprot,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp,
   output logic        arvalid,
   input  logic        arready,
   output logic [15:0] araddr,
   output logic [2:0]  arprot,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WRESP,
      RADDR,
      RDATA,
      RESP
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        live;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_done;
   logic        w_done;
   logic [31:0] rdata_q;
   logic [1:0]  resp_q;
   logic        accept;

   assign accept = cmd_valid && cmd_ready;

   // live holds cmd_ready off while in reset and for nothing longer than the first clock after release
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         live    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         rdata_q <= '0;
         resp_q  <= '0;
      end else begin
         state <= state_next;
         live  <= 1'b1;
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (awvalid && awready) aw_done <= 1'b1;
         if (wvalid && wready)   w_done  <= 1'b1;
         if (state == WRESP && bvalid) begin
            rdata_q <= '0;
            resp_q  <= bresp;
         end
         if (state == RDATA && rvalid) begin
            rdata_q <= rdata;
            resp_q  <= rresp;
         end
      end
   end

   // AW and W retire independently; the done flags stop each valid after its own handshake
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = live;
            if (cmd_valid && live) state_next = cmd_write ? WRITE : RADDR;
         end
         WRITE: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
            if ((aw_done || awready) && (w_done || wready)) state_next = WRESP;
         end
         WRESP: begin
            bready = 1'b1;
            if (bvalid) state_next = RESP;
         end
         RADDR: begin
            arvalid = 1'b1;
            if (arready) state_next = RDATA;
         end
         RDATA: begin
            rready = 1'b1;
            if (rvalid) state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign awaddr    = addr_q;
   assign araddr    = addr_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign awprot    = PROT;
   assign arprot    = PROT;
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi4_master.sv
// Self-checking bench for axi4_master: scripted subordinate, scoreboard of expected completions.
module tb_axi4_master;

   logic        aclk;
   logic        aresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        awvalid;
   logic        awready;
   logic [15:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [15:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   axi4_master #(.PROT(3'b000)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      #2;
      checks++;
      if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                  {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
      end
      checks++;
      if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_rsp: got %h/%b expected 0/0", rsp_rdata, rsp_resp);
      end
      step();
      step();
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_held_ready: got %b expected 0", cmd_ready);
      end
      #3 aresetn = 1'b1;
      step();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_write_basic();
      exp_t e;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010;
      cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
      sb.push_back('{32'h0, 2'b00});
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wr_accept: cmd_ready got %b expected 1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      cmd_wdata = 32'h0;
      checks++;
      if ({awvalid, wvalid, arvalid} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL wr_cycle1_valids: got %b expected 110", {awvalid, wvalid, arvalid});
      end
      checks++;
      if (awaddr !== 16'h0010 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF || awprot !== 3'b000) begin
         errors++;
         $display("[TB] FAIL wr_payload: got %h %h %h %b expected 0010 deadbeef f 000",
                  awaddr, wdata, wstrb, awprot);
      end
      step();
      checks++;
      if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL wr_cycle2: got %b expected 0010", {awvalid, wvalid, bready, rsp_valid});
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wr_latency: rsp_valid in cycle 3 got %b expected 1", rsp_valid);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
            errors++;
            $display("[TB] FAIL wr_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_resp, e.rdata, e.resp);
         end
      end
      step();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wr_return_idle: ready/valid got %b%b expected 10", cmd_ready, rsp_valid);
      end
   endtask

   task automatic test_read_basic();
      exp_t e;
      arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00; rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
      sb.push_back('{32'hCAFEF00D, 2'b00});
      step();
      cmd_valid = 1'b0;
      cmd_addr = 16'hFFFF;
      checks++;
      if ({arvalid, awvalid, wvalid, rready} !== 4'b1000 || araddr !== 16'h0020 || arprot !== 3'b000) begin
         errors++;
         $display("[TB] FAIL rd_cycle1: got %b addr %h expected 1000 addr 0020",
                  {arvalid, awvalid, wvalid, rready}, araddr);
      end
      step();
      checks++;
      if ({arvalid, rready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rd_cycle2: got %b expected 01", {arvalid, rready});
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rd_latency: rsp_valid in cycle 3 got %b expected 1", rsp_valid);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
            errors++;
            $display("[TB] FAIL rd_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_resp, e.rdata, e.resp);
         end
      end
      step();
   endtask

   task automatic test_wready_delay();
      exp_t e;
      int aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_phases = 0, first_rsp = 0, bad_data = 0;
      logic prev_b = 1'b0;
      awready = 1'b1; wready = 1'b0; bvalid = 1'b1; bresp = 2'b11; rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0044;
      cmd_wdata = 32'h12345678; cmd_wstrb = 4'h5;
      sb.push_back('{32'h0, 2'b11});
      for (int cyc = 1; cyc <= 12; cyc++) begin
         step();
         cmd_valid = 1'b0;
         cmd_wdata = 32'hFFFFFFFF;
         wready = (cyc >= 5);
         aw_cnt += int'(awvalid);
         w_cnt  += int'(wvalid);
         b_cnt  += int'(bready);
         if (bready && !prev_b) b_phases++;
         prev_b = bready;
         if (wvalid && (wdata !== 32'h12345678 || wstrb !== 4'h5 || awaddr !== 16'h0044)) bad_data++;
         if (rsp_valid && first_rsp == 0) first_rsp = cyc;
         if (rsp_valid && rsp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
               errors++;
               $display("[TB] FAIL wd_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_resp, e.rdata, e.resp);
            end
         end
      end
      checks++;
      if (aw_cnt != 1) begin
         errors++;
         $display("[TB] FAIL wd_awvalid_cycles: got %0d expected 1", aw_cnt);
      end
      checks++;
      if (w_cnt != 5) begin
         errors++;
         $display("[TB] FAIL wd_wvalid_cycles: got %0d expected 5", w_cnt);
      end
      checks++;
      if (b_phases != 1 || b_cnt != 1) begin
         errors++;
         $display("[TB] FAIL wd_bready: phases %0d cycles %0d expected 1 and 1", b_phases, b_cnt);
      end
      checks++;
      if (first_rsp != 7 || bad_data != 0) begin
         errors++;
         $display("[TB] FAIL wd_timing: rsp cycle %0d unstable %0d expected 7 and 0", first_rsp, bad_data);
      end
   endtask

   task automatic test_read_err_hold();
      exp_t e;
      int v_cnt = 0, first_rsp = 0, unstable = 0, ready_cnt = 0;
      arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b10; rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
      sb.push_back('{32'h0BADF00D, 2'b10});
      for (int cyc = 1; cyc <= 10; cyc++) begin
         step();
         cmd_valid = 1'b0;
         if (cyc >= 3) begin
            rdata = 32'hFFFFFFFF;
            rresp = 2'b00;
         end
         rsp_ready = (cyc >= 6);
         if (cyc <= 6 && cmd_ready) ready_cnt++;
         if (rsp_valid) begin
            v_cnt++;
            if (first_rsp == 0) first_rsp = cyc;
            if (rsp_resp !== 2'b10 || rsp_rdata !== 32'h0BADF00D) unstable++;
            if (rsp_ready && sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                  errors++;
                  $display("[TB] FAIL re_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_resp, e.rdata, e.resp);
               end
            end
         end
      end
      checks++;
      if (v_cnt != 4 || first_rsp != 3) begin
         errors++;
         $display("[TB] FAIL re_hold: valid cycles %0d first %0d expected 4 and 3", v_cnt, first_rsp);
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("[TB] FAIL re_stable: unstable cycles %0d expected 0", unstable);
      end
      checks++;
      if (ready_cnt != 0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL re_cmd_ready: busy-high %0d final %b expected 0 and 1", ready_cnt, cmd_ready);
      end
   endtask

   task automatic test_reset_midflight();
      int spurious = 0;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050;
      cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hF;
      step();
      cmd_valid = 1'b0;
      step();
      checks++;
      if (bready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rm_in_wresp: bready got %b expected 1", bready);
      end
      #3 aresetn = 1'b0;
      #1;
      checks++;
      if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0 ||
          rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rm_async: got %b %h/%b expected 0000000 0/0",
                  {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, rsp_rdata, rsp_resp);
      end
      bvalid = 1'b1;
      step();
      #3 aresetn = 1'b1;
      step();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rm_release_ready: got %b expected 1", cmd_ready);
      end
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (rsp_valid || bready) spurious++;
         step();
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("[TB] FAIL rm_no_completion: spurious cycles %0d expected 0", spurious);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] r;
      logic        is_wr;
      logic [15:0] a;
      int          n, lat;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; arready = 1'b1; rvalid = 1'b1; rsp_ready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         r = $urandom; a = r[15:0];
         is_wr = r[16];
         r = $urandom; rdata = r;
         r = $urandom; rresp = r[1:0]; bresp = r[3:2];
         cmd_wdata = $urandom; cmd_wstrb = r[7:4];
         cmd_valid = 1'b1; cmd_write = is_wr; cmd_addr = a;
         if (is_wr) sb.push_back('{32'h0, bresp});
         else sb.push_back('{rdata, rresp});
         n = 0;
         while (cmd_ready !== 1'b1 && n < 10) begin
            step();
            n++;
         end
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept[%0d]: cmd_ready got %b expected 1", t, cmd_ready);
         end
         step();
         cmd_valid = 1'b0;
         checks++;
         if ((is_wr ? awaddr : araddr) !== a) begin
            errors++;
            $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", t, is_wr ? awaddr : araddr, a);
         end
         lat = 1;
         while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
         end
         checks++;
         if (lat != 3) begin
            errors++;
            $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 3", t, lat);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
               errors++;
               $display("[TB] FAIL b2b_rsp[%0d]: got %h/%b expected %h/%b", t, rsp_rdata, rsp_resp, e.rdata, e.resp);
            end
         end
         step();
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_reready[%0d]: got %b expected 1", t, cmd_ready);
         end
      end
   endtask

   initial begin
      aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      bresp = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      test_reset();
      test_write_basic();
      test_read_basic();
      test_wready_delay();
      test_read_err_hold();
      test_reset_midflight();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/axi4_master.md
AXI4_MASTER -- requirements
Module: axi4_master

Interface
REQ-001 SHALL have parameter PROT, default 3'b000, value driven on awprot and arprot for every transaction.
REQ-002 SHALL have port aclk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  user command present.
REQ-005 SHALL have port cmd_ready  output  1  block accepts a command.
REQ-006 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port cmd_addr  input  16  byte address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port cmd_wstrb  input  4  write byte strobes.
REQ-010 SHALL have port rsp_valid  output  1  completion present.
REQ-011 SHALL have port rsp_ready  input  1  user accepts the completion.
REQ-012 SHALL have port rsp_rdata  output  32  read data (0 for writes).
REQ-013 SHALL have port rsp_resp  output  2  captured bresp/rresp.
REQ-014 SHALL have AXI4-Lite write-address ports awvalid out 1, awready in 1, awaddr out 16, awprot out 3.
REQ-015 SHALL have AXI4-Lite write-data ports wvalid out 1, wready in 1, wdata out 32, wstrb out 4.
REQ-016 SHALL have AXI4-Lite write-response ports bvalid in 1, bready out 1, bresp in 2.
REQ-017 SHALL have AXI4-Lite read-address ports arvalid out 1, arready in 1, araddr out 16, arprot out 3.
REQ-018 SHALL have AXI4-Lite read-data ports rvalid in 1, rready out 1, rdata in 32, rresp in 2.

Function
REQ-019 SHALL implement the FSM states IDLE, WRITE, WRESP, RADDR, RDATA and RESP, with one transaction outstanding at most.
REQ-020 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready it SHALL register addr, wdata, wstrb and write, then enter WRITE (write) or RADDR (read).
REQ-021 SHALL drive awaddr, wdata, wstrb and araddr from the registered command only, stable for the whole transaction.
REQ-022 SHALL assert awvalid and wvalid together in the first WRITE cycle, one cycle after acceptance.
REQ-023 SHALL handle AW and W independently: each valid drops the cycle after its own handshake; same-cycle or either-order completion SHALL be legal.
REQ-024 SHALL move from WRITE to WRESP on the cycle both AW and W handshakes have completed.
REQ-025 SHALL never deassert a valid before its handshake, and SHALL never issue a second AW or W beat.
REQ-026 SHALL assert bready only in WRESP; on bvalid it SHALL capture bresp, set the rdata register to 0, and enter RESP.
REQ-027 SHALL assert arvalid in RADDR until arready, then enter RDATA; it SHALL assert rready only in RDATA.
REQ-028 SHALL, in RDATA on rvalid, capture rdata and rresp and enter RESP.
REQ-029 SHALL, in RESP, assert rsp_valid with rsp_rdata/rsp_resp stable until rsp_ready, then return to IDLE; cmd_ready SHALL reassert the following cycle.
REQ-030 SHALL have a best-case latency, with a zero-wait subordinate, of rsp_valid in cycle 3 after the acceptance cycle 0 for both writes and reads.
REQ-031 SHALL ignore bvalid/rvalid outside WRESP/RDATA and SHALL pass SLVERR/DECERR through unmodified.

Reset
REQ-032 SHALL, while aresetn=0, immediately force state IDLE and drive awvalid, wvalid, arvalid, bready, rready, rsp_valid and cmd_ready at 0, with rsp_rdata=0 and rsp_resp=0.
REQ-033 SHALL abandon any in-flight transaction on reset mid-operation without issuing a completion, and SHALL assert cmd_ready in the first clock after aresetn rises.

Verification
REQ-034 SHALL be verified with: write addr 16'h0010 data 32'hDEADBEEF strb 4'hF, all readies high -> aw/w handshakes in cycle 1, rsp_valid cycle 3, rsp_resp=0, rsp_rdata=0.
REQ-035 SHALL be verified with: read addr 16'h0020, rdata 32'hCAFEF00D rresp 2'b00 -> rsp_rdata=32'hCAFEF00D, rsp_resp=0.
REQ-036 SHALL be verified with: write, wready delayed 4 cycles after awready -> awvalid drops after 1 cycle, wvalid held 5 cycles, a single bready phase.
REQ-037 SHALL be verified with: read, rresp=2'b10 and rsp_ready held low 3 cycles -> rsp_valid and rsp_resp=2'b10 stable 4 cycles, cmd_ready low throughout.
REQ-038 SHALL be verified with: aresetn pulsed low in WRESP -> all valids/readies 0 asynchronously, no rsp_valid, cmd_ready=1 one clock after release.
